sap_ram16x8: RTL and testbench
==============================

Name: sap_ram16x8

Overview:
- 16-word x 8-bit program/data memory for the SAP-style datapath.
- Consumer ("reader") end of the 4-bit memory address register (MAR).
- Run mode: reads the word addressed by the MAR output and drives it onto the shared 8-bit bus under an active-low enable.
- Program mode: a valid/ready loader writes words, reads each one back to verify it, and counts the words loaded.

Parameters:
- ADDR_W, 4, address width (depth = 2**ADDR_W = 16)
- DATA_W, 8, word width
- RESET_FILL, 8'h00, value every word takes on reset

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- clr_n  input  1  asynchronous, active-low reset
- mar_addr  input  4  address from the MAR output
- ce_n  input  1  bus output enable, active low
- bus_out  output  8  bus drive; high-Z unless enabled
- prog_mode  input  1  1 = program mode, 0 = run mode
- prog_valid  input  1  loader presents a word
- prog_addr  input  4  loader target address
- prog_data  input  8  loader data
- prog_ready  output  1  loader may present the next word
- prog_err  output  1  sticky verify-mismatch flag
- loaded_cnt  output  5  number of successful writes, saturating at 16

Behaviour:
- Reset (clr_n=0, asynchronous):
  - every word = RESET_FILL
  - rdata = 8'h00
  - FSM = P_IDLE
  - prog_ready=0, prog_err=0, loaded_cnt=0
  - bus_out = Z
- Run-mode read path:
  - Every clk with prog_mode=0: rdata <= mem[mar_addr].
  - Read latency is 1 cycle from a mar_addr change.
  - bus_out = rdata when (ce_n=0 && prog_mode=0); otherwise 8'hZZ.
  - ce_n is combinational to bus_out (no clock needed to release the bus).
- Loader FSM states: P_IDLE, P_WRITE, P_VERIFY.
  - P_IDLE: prog_ready = prog_mode. On prog_mode && prog_valid && prog_ready: latch prog_addr and prog_data into a_q/d_q, deassert prog_ready, go to P_WRITE.
  - P_WRITE: mem[a_q] <= d_q; go to P_VERIFY. prog_ready=0.
  - P_VERIFY: compare mem[a_q] with d_q.
    - Mismatch: prog_err <= 1 (sticky until reset).
    - Match: loaded_cnt <= min(loaded_cnt+1, 16).
    - Go to P_IDLE.
  - Handshake throughput: one word per 3 cycles; a transfer occurs only on a valid&&ready edge.
- prog_mode falling during P_WRITE or P_VERIFY: the in-flight word completes, then the FSM returns to P_IDLE with prog_ready=0.
- prog_valid while prog_mode=0: ignored, no write.
- Rewriting an address that already holds data: allowed. loaded_cnt still increments, saturating at 16, never wrapping to 0.
- Any write to the address currently on mar_addr: the new value is visible in rdata one cycle after the write cycle, once back in run mode.
- rdata is frozen during program mode.
- Reset asserted mid-transfer: the word may or may not be written. After reset everything equals RESET_FILL, so the result is deterministic.

Decomposition:
- Shared package sap_pkg holds:
  - SAP_ADDR_W=4, SAP_DATA_W=8
  - loader state enum {P_IDLE, P_WRITE, P_VERIFY}
  - LOAD_CNT_MAX=16
- One natural sub-module: sap_ram_array.
  - 16x8 flop array with async clear to RESET_FILL.
  - One synchronous write port.
  - Two combinational read ports: run-mode read and verify read.
- The loader FSM, counters and tristate driver stay in the top module.

Test Plan:
- Reset, then prog_mode=0, ce_n=0, mar_addr sweeps 0..15 -> bus_out=8'h00 at every address; ce_n=1 -> bus_out=Z.
- prog_mode=1; load addr 4'h3=8'hA5 and 4'hF=8'h3C; prog_mode=0; mar_addr=3, ce_n=0 -> bus_out=8'hA5 one cycle later; mar_addr=F -> 8'h3C; loaded_cnt=2; prog_err=0.
- Hold prog_valid=1 continuously for 5 words -> prog_ready pulses 1 of every 3 cycles; exactly 5 writes; loaded_cnt=5.
- Write 20 words (some addresses repeated) -> loaded_cnt saturates at 16 and never wraps to 0.
- prog_mode dropped in the P_WRITE cycle of addr 7=8'h11 -> word written, then mar_addr=7 gives bus_out=8'h11. clr_n pulse mid-P_VERIFY -> all words 8'h00, loaded_cnt=0, prog_ready=0.
- Force a mismatch (bind override of the array write enable in P_WRITE) -> prog_err=1 and stays 1 until clr_n.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared constants and loader state type for the SAP-style memory slice.
package sap_pkg;

    localparam int unsigned SAP_ADDR_W   = 4;
    localparam int unsigned SAP_DATA_W   = 8;
    localparam int unsigned LOAD_CNT_MAX = 16;

    typedef enum logic [1:0] {
        P_IDLE,
        P_WRITE,
        P_VERIFY
    } loader_state_e;

endpackage

// File: rtl/sap_ram_array.sv
// Flop-based word array: async clear to a fill value, one write port,
// two independent combinational read ports (run path and verify path).
module sap_ram_array #(
    parameter int unsigned       ADDR_W     = 4,
    parameter int unsigned       DATA_W     = 8,
    parameter logic [DATA_W-1:0] RESET_FILL = '0
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_run,
    output logic [DATA_W-1:0] o_rdata_run,
    input  logic [ADDR_W-1:0] i_raddr_vfy,
    output logic [DATA_W-1:0] o_rdata_vfy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_FILL;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_run = r_mem[i_raddr_run];
    assign o_rdata_vfy = r_mem[i_raddr_vfy];

endmodule

// File: rtl/sap_ram16x8.sv
// 16x8 SAP program/data memory: registered run-mode read onto a tristate bus,
// plus a valid/ready loader that writes, reads back to verify, and counts words.
module sap_ram16x8
    import sap_pkg::*;
#(
    parameter int unsigned       ADDR_W     = SAP_ADDR_W,
    parameter int unsigned       DATA_W     = SAP_DATA_W,
    parameter logic [DATA_W-1:0] RESET_FILL = 8'h00
) (
    input  logic                                  clk,
    input  logic                                  clr_n,
    input  logic [ADDR_W-1:0]                     mar_addr,
    input  logic                                  ce_n,
    output logic [DATA_W-1:0]                     bus_out,
    input  logic                                  prog_mode,
    input  logic                                  prog_valid,
    input  logic [ADDR_W-1:0]                     prog_addr,
    input  logic [DATA_W-1:0]                     prog_data,
    output logic                                  prog_ready,
    output logic                                  prog_err,
    output logic [$clog2(LOAD_CNT_MAX + 1)-1:0]   loaded_cnt
);

    localparam int unsigned      CNT_W   = $clog2(LOAD_CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOAD_CNT_MAX);

    loader_state_e     r_state;
    loader_state_e     w_state_d;
    logic [ADDR_W-1:0] r_a;
    logic [DATA_W-1:0] r_d;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_latch;
    logic              w_mem_we;
    logic              w_vfy_match;
    logic [DATA_W-1:0] w_rdata_run;
    logic [DATA_W-1:0] w_rdata_vfy;

    sap_ram_array #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RESET_FILL (RESET_FILL)
    ) u_array (
        .clk         (clk),
        .clr_n       (clr_n),
        .i_we        (w_mem_we),
        .i_waddr     (r_a),
        .i_wdata     (r_d),
        .i_raddr_run (mar_addr),
        .o_rdata_run (w_rdata_run),
        .i_raddr_vfy (r_a),
        .o_rdata_vfy (w_rdata_vfy)
    );

    // Kept as a standalone net so the write strobe can be overridden in isolation.
    assign w_mem_we    = (r_state == P_WRITE);
    assign w_vfy_match = (w_rdata_vfy == r_d);

    always_comb begin
        w_state_d  = r_state;
        w_latch    = 1'b0;
        prog_ready = 1'b0;
        unique case (r_state)
            P_IDLE: begin
                prog_ready = prog_mode;
                if (prog_mode && prog_valid) begin
                    w_latch   = 1'b1;
                    w_state_d = P_WRITE;
                end
            end
            P_WRITE:  w_state_d = P_VERIFY;
            P_VERIFY: w_state_d = P_IDLE;
            default:  w_state_d = P_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= P_IDLE;
            r_a     <= '0;
            r_d     <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_latch) begin
                r_a <= prog_addr;
                r_d <= prog_data;
            end
            // Read register holds its last value for the whole program-mode window.
            if (!prog_mode) begin
                r_rdata <= w_rdata_run;
            end
            if (r_state == P_VERIFY) begin
                if (!w_vfy_match) begin
                    r_err <= 1'b1;
                end else if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus_out    = (!ce_n && !prog_mode) ? r_rdata : {DATA_W{1'bz}};
    assign prog_err   = r_err;
    assign loaded_cnt = r_cnt;

endmodule

// File: tb/tb_sap_ram16x8.sv
// Bench for sap_ram16x8: directed and randomized steps against an array-based memory model.
module tb_sap_ram16x8;

    logic       clk        = 1'b0;
    logic       clr_n      = 1'b0;
    logic [3:0] mar_addr   = 4'h0;
    logic       ce_n       = 1'b1;
    wire  [7:0] w_bus;
    logic       prog_mode  = 1'b0;
    logic       prog_valid = 1'b0;
    logic [3:0] prog_addr  = 4'h0;
    logic [7:0] prog_data  = 8'h00;
    logic       prog_ready;
    logic       prog_err;
    logic [4:0] loaded_cnt;

    // Weak pull-ups make a released bus read back as 8'hFF.
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (w_bus[g]);
    end

    sap_ram16x8 dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .mar_addr   (mar_addr),
        .ce_n       (ce_n),
        .bus_out    (w_bus),
        .prog_mode  (prog_mode),
        .prog_valid (prog_valid),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_ready (prog_ready),
        .prog_err   (prog_err),
        .loaded_cnt (loaded_cnt)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] mem_m [16];
    int         cnt_m;
    logic       err_m;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        cnt_m = 0;
        err_m = 1'b0;
    endtask

    // ok=0 models a word whose write never landed, so readback disagrees.
    task automatic model_write(input logic [3:0] a, input logic [7:0] d, input bit ok);
        if (ok) begin
            mem_m[a] = d;
            cnt_m    = (cnt_m >= 16) ? 16 : cnt_m + 1;
        end else begin
            err_m = 1'b1;
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 8; i++) begin
            if (prog_ready === 1'b1) break;
            @(negedge clk);
        end
        check("ready_idle", {7'b0, prog_ready}, 8'h01);
    endtask

    // Entered and left on a negedge with the loader idle.
    task automatic load(input logic [3:0] a, input logic [7:0] d, input bit ok);
        wait_ready();
        prog_valid = 1'b1;
        prog_addr  = a;
        prog_data  = d;
        @(negedge clk);
        prog_valid = 1'b0;
        check("ready_write", {7'b0, prog_ready}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        model_write(a, d, ok);
        check("cnt_load", {3'b0, loaded_cnt}, 8'(cnt_m));
        check("err_load", {7'b0, prog_err}, {7'b0, err_m});
    endtask

    task automatic read_check(input logic [3:0] a);
        mar_addr = a;
        ce_n     = 1'b0;
        @(negedge clk);
        check("bus_read", w_bus, mem_m[a]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] wa [5];
        logic [7:0] wd [5];
        int         k;
        int         hs;
        bit         took;
        logic       r;
        logic [3:0] a;

        model_clear();
        repeat (2) @(negedge clk);
        check("rst_cnt", {3'b0, loaded_cnt}, 8'h00);
        check("rst_err", {7'b0, prog_err}, 8'h00);
        check("rst_ready", {7'b0, prog_ready}, 8'h00);
        check("rst_bus", w_bus, 8'hFF);
        clr_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) read_check(4'(i));
        ce_n = 1'b1;
        #1 check("bus_release_ce", w_bus, 8'hFF);
        ce_n      = 1'b0;
        prog_mode = 1'b1;
        #1 check("bus_release_prog", w_bus, 8'hFF);
        @(negedge clk);

        load(4'h3, 8'hA5, 1'b1);
        load(4'hF, 8'h3C, 1'b1);
        prog_mode = 1'b0;
        read_check(4'h3);
        read_check(4'hF);
        check("cnt_two", {3'b0, loaded_cnt}, 8'h02);
        check("err_clean", {7'b0, prog_err}, 8'h00);

        // Streaming: valid held high, one accept every third cycle.
        prog_mode = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            wa[i] = 4'($urandom_range(0, 15));
            wd[i] = 8'($urandom);
        end
        k = 0; hs = 0; took = 1'b0;
        prog_valid = 1'b1;
        prog_addr  = wa[0];
        prog_data  = wd[0];
        for (int i = 0; i < 15; i++) begin
            if (took) begin
                k++;
                if (k < 5) begin
                    prog_addr = wa[k];
                    prog_data = wd[k];
                end else begin
                    prog_valid = 1'b0;
                end
            end
            r = prog_ready;
            check("stream_ready", {7'b0, r}, (i % 3 == 0) ? 8'h01 : 8'h00);
            took = (r === 1'b1) && prog_valid;
            if (took) begin
                hs++;
                model_write(wa[k], wd[k], 1'b1);
            end
            @(negedge clk);
        end
        check("stream_handshakes", 8'(hs), 8'h05);
        check("stream_cnt", {3'b0, loaded_cnt}, 8'(cnt_m));
        prog_mode = 1'b0;
        for (int i = 0; i < 5; i++) read_check(wa[i]);

        // Saturation: 20 more words, repeats included.
        prog_mode = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 20; j++) begin
            a = (j < 8) ? 4'(j) : 4'($urandom_range(0, 15));
            load(a, 8'($urandom), 1'b1);
            check("cnt_nonzero", {7'b0, loaded_cnt == 5'd0}, 8'h00);
        end
        check("cnt_sat", {3'b0, loaded_cnt}, 8'd16);

        // Drop prog_mode while the word is in P_WRITE.
        wait_ready();
        prog_valid = 1'b1;
        prog_addr  = 4'h7;
        prog_data  = 8'h11;
        @(negedge clk);
        prog_mode  = 1'b0;
        prog_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_write(4'h7, 8'h11, 1'b1);
        check("drop_ready", {7'b0, prog_ready}, 8'h00);
        read_check(4'h7);
        check("drop_cnt", {3'b0, loaded_cnt}, 8'd16);

        // Reset pulse while a word is in P_VERIFY.
        prog_mode = 1'b1;
        @(negedge clk);
        wait_ready();
        prog_valid = 1'b1;
        prog_addr  = 4'h9;
        prog_data  = 8'h77;
        @(negedge clk);
        prog_valid = 1'b0;
        @(negedge clk);
        prog_mode = 1'b0;
        #1 clr_n = 1'b0;
        #2 clr_n = 1'b1;
        model_clear();
        check("clr_cnt", {3'b0, loaded_cnt}, 8'h00);
        check("clr_ready", {7'b0, prog_ready}, 8'h00);
        check("clr_err", {7'b0, prog_err}, 8'h00);
        @(negedge clk);
        for (int i = 0; i < 16; i++) read_check(4'(i));

        // Suppressed write strobe must surface as a sticky verify error.
        prog_mode = 1'b1;
        @(negedge clk);
        force dut.w_mem_we = 1'b0;
        load(4'h5, 8'h5A, 1'b0);
        release dut.w_mem_we;
        load(4'h6, 8'hC3, 1'b1);
        prog_mode = 1'b0;
        read_check(4'h5);
        read_check(4'h6);
        check("err_sticky", {7'b0, prog_err}, 8'h01);

        for (int i = 0; i < 8; i++) read_check(4'($urandom_range(0, 15)));

        @(negedge clk);
        clr_n = 1'b0;
        #1 model_clear();
        check("final_err", {7'b0, prog_err}, 8'h00);
        check("final_cnt", {3'b0, loaded_cnt}, 8'h00);
        clr_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
